// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, constants and helpers for the display scan controller
package display_pkg;

    typedef enum logic {
        GUARDA = 1'b0,
        ATIVO  = 1'b1
    } estado_t;

    localparam int LARGURA_BCD = 4;
    localparam int MAX_DIGITOS = 32;

    function automatic logic [MAX_DIGITOS-1:0] um_quente(input int indice);
        logic [MAX_DIGITOS-1:0] base;
        base = {{(MAX_DIGITOS-1){1'b0}}, 1'b1};
        return base << indice;
    endfunction

endpackage

// File: rtl/gerador_pisca.sv
// rtl/gerador_pisca.sv - free-running blink phase divider, toggles every CICLOS_PISCA cycles
module gerador_pisca #(
    parameter int CICLOS_PISCA = 12500000
) (
    input  logic Clock,
    input  logic Reset,
    output logic Fase
);

    localparam int CW = (CICLOS_PISCA > 1) ? $clog2(CICLOS_PISCA) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(CICLOS_PISCA - 1);

    logic [CW-1:0] contador;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            contador <= '0;
            Fase     <= 1'b0;
        end else if (contador == ULTIMO) begin
            contador <= '0;
            Fase     <= ~Fase;
        end else begin
            contador <= contador + 1'b1;
        end
    end

endmodule

// File: rtl/controle_display.sv
// rtl/controle_display.sv - seven-segment digit scan controller; DISPLAY_PISCA_EN builds digit blinking
module controle_display
    import display_pkg::*;
#(
    parameter int NUM_DIGITOS       = 4,
    parameter int CICLOS_POR_DIGITO = 50000,
    parameter int CICLOS_GUARDA     = 16,
    parameter int CICLOS_PISCA      = 12500000
) (
    input  logic                                 Clock,
    input  logic                                 Reset,
    input  logic [LARGURA_BCD*NUM_DIGITOS-1:0]   Digitos,
    input  logic                                 Apagar_Zero,
    input  logic [NUM_DIGITOS-1:0]               Seleciona_Pisca,
    output logic [LARGURA_BCD-1:0]               Num_Binario,
    output logic [NUM_DIGITOS-1:0]               Habilita_Digito,
    output logic [$clog2(NUM_DIGITOS)-1:0]       Digito_Atual
);

    localparam int IDX_W      = $clog2(NUM_DIGITOS);
    localparam int MAX_CICLOS = (CICLOS_POR_DIGITO > CICLOS_GUARDA) ? CICLOS_POR_DIGITO : CICLOS_GUARDA;
    localparam int CNT_W      = (MAX_CICLOS > 1) ? $clog2(MAX_CICLOS) : 1;

    localparam logic [CNT_W-1:0] FIM_ATIVO     = CNT_W'(CICLOS_POR_DIGITO - 1);
    localparam logic [CNT_W-1:0] FIM_GUARDA    = CNT_W'(CICLOS_GUARDA - 1);
    localparam logic [IDX_W-1:0] ULTIMO_DIGITO = IDX_W'(NUM_DIGITOS - 1);

    estado_t                               estado;
    logic [CNT_W-1:0]                      contador;
    logic [LARGURA_BCD*NUM_DIGITOS-1:0]    quadro;
    logic [NUM_DIGITOS-1:0]                apagado;
    logic                                  zeros_acima;
    logic [NUM_DIGITOS-1:0]                mascara_pisca;
    logic [NUM_DIGITOS-1:0]                habilita_calc;
    logic [IDX_W-1:0]                      proximo_digito;

`ifdef DISPLAY_PISCA_EN
    logic fase_pisca;

    gerador_pisca #(
        .CICLOS_PISCA (CICLOS_PISCA)
    ) u_gerador_pisca (
        .Clock (Clock),
        .Reset (Reset),
        .Fase  (fase_pisca)
    );

    assign mascara_pisca = {NUM_DIGITOS{fase_pisca}} & Seleciona_Pisca;
`else
    localparam int unused_ciclos_pisca = CICLOS_PISCA;
    logic unused_seleciona;

    assign unused_seleciona = ^Seleciona_Pisca;
    assign mascara_pisca    = '0;
`endif

    // A digit is blanked only if it and every more significant snapshot nibble is zero
    always_comb begin
        apagado     = '0;
        zeros_acima = Apagar_Zero;
        for (int i = NUM_DIGITOS - 1; i > 0; i--) begin
            zeros_acima = zeros_acima && (quadro[i*LARGURA_BCD +: LARGURA_BCD] == '0);
            apagado[i]  = zeros_acima;
        end
    end

    assign proximo_digito = (Digito_Atual == ULTIMO_DIGITO) ? '0 : Digito_Atual + 1'b1;
    assign habilita_calc  = NUM_DIGITOS'(um_quente(int'(Digito_Atual))) & ~apagado & ~mascara_pisca;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado          <= GUARDA;
            contador        <= '0;
            Digito_Atual    <= '0;
            Num_Binario     <= '0;
            Habilita_Digito <= '0;
            quadro          <= Digitos;
        end else begin
            case (estado)
                GUARDA: begin
                    Habilita_Digito <= '0;
                    Num_Binario     <= quadro[int'(Digito_Atual)*LARGURA_BCD +: LARGURA_BCD];
                    if (contador == FIM_GUARDA) begin
                        estado          <= ATIVO;
                        contador        <= '0;
                        Habilita_Digito <= habilita_calc;
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end
                ATIVO: begin
                    if (contador == FIM_ATIVO) begin
                        estado          <= GUARDA;
                        contador        <= '0;
                        Habilita_Digito <= '0;
                        Digito_Atual    <= proximo_digito;
                        // Wrapping to digit 0 starts a new frame: take a fresh snapshot
                        if (proximo_digito == '0) begin
                            quadro      <= Digitos;
                            Num_Binario <= Digitos[LARGURA_BCD-1:0];
                        end else begin
                            Num_Binario <= quadro[int'(proximo_digito)*LARGURA_BCD +: LARGURA_BCD];
                        end
                    end else begin
                        contador        <= contador + 1'b1;
                        Habilita_Digito <= habilita_calc;
                    end
                end
                default: begin
                    estado   <= GUARDA;
                    contador <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_display.sv
// tb/tb_controle_display.sv - scoreboard bench for controle_display (DISPLAY_PISCA_EN aware)
module tb_controle_display;

    localparam int ND    = 4;
    localparam int CPD   = 4;
    localparam int CG    = 1;
    localparam int CP    = 20;
    localparam int FRAME = ND * (CPD + CG);

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] Digitos;
    logic        Apagar_Zero;
    logic [3:0]  Seleciona_Pisca;
    logic [3:0]  Num_Binario;
    logic [3:0]  Habilita_Digito;
    logic [1:0]  Digito_Atual;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] nib;
        logic [3:0] en;
    } slot_t;

    slot_t fila[$];
    slot_t atual = '0;
    int    n_assert = 0;
    int    n_fail = 0;
    int    quadro_num = 0;
    int    pos = -1;
    bit    mon_en = 1'b0;
    logic [1:0] anterior = '0;

    controle_display #(
        .NUM_DIGITOS       (ND),
        .CICLOS_POR_DIGITO (CPD),
        .CICLOS_GUARDA     (CG),
        .CICLOS_PISCA      (CP)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Digitos         (Digitos),
        .Apagar_Zero     (Apagar_Zero),
        .Seleciona_Pisca (Seleciona_Pisca),
        .Num_Binario     (Num_Binario),
        .Habilita_Digito (Habilita_Digito),
        .Digito_Atual    (Digito_Atual)
    );

    always #5 Clock = ~Clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_assert++;
        if (obs !== esp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
        end
    endtask

    function automatic logic [3:0] en_esperado(input logic [15:0] d, input logic apz,
                                               input int fnum, input int i);
        logic [3:0] um;
        um = 4'b0001;
        if (apz && i > 0 && (d >> (4 * i)) == 16'h0)
            return 4'b0000;
`ifdef DISPLAY_PISCA_EN
        if ((fnum % 2) == 0 && Seleciona_Pisca[i])
            return 4'b0000;
`else
        if (fnum < 0)
            return 4'b0000;
`endif
        return um << i;
    endfunction

    task automatic empilha_quadro(input logic [15:0] d, input logic apz, input int fnum);
        slot_t s;
        for (int i = 0; i < ND; i++) begin
            s.idx = 2'(i);
            s.nib = d[4*i +: 4];
            s.en  = en_esperado(d, apz, fnum, i);
            fila.push_back(s);
        end
    endtask

    // Runs one frame; at offset ofs drives the data for the next frame and queues its expectation
    task automatic quadro(input logic [15:0] d_prox, input logic apz_prox, input int ofs);
        repeat (ofs) @(posedge Clock);
        #1;
        Digitos     = d_prox;
        Apagar_Zero = apz_prox;
        empilha_quadro(d_prox, apz_prox, quadro_num + 1);
        repeat (FRAME - ofs) @(posedge Clock);
        #1;
        quadro_num++;
    endtask

    always @(negedge Clock) begin
        if (Reset) begin
            pos = -1;
        end else begin
            if (pos < 0 || Digito_Atual != anterior)
                pos = 0;
            else
                pos++;
            anterior = Digito_Atual;
            if (mon_en) begin
                verifica("overlap", 32'($countones(Habilita_Digito) <= 1), 32'd1);
                if (pos < CG) begin
                    verifica("guard_dark", 32'(Habilita_Digito), 32'd0);
                end else if (pos < CG + CPD) begin
                    if (pos == CG) begin
                        if (fila.size() == 0) begin
                            verifica("underflow", 32'(fila.size()), 32'd1);
                        end else begin
                            atual = fila.pop_front();
                            verifica("digit_idx", 32'(Digito_Atual), 32'(atual.idx));
                        end
                    end
                    verifica("enable", 32'(Habilita_Digito), 32'(atual.en));
                    verifica("nibble", 32'(Num_Binario), 32'(atual.nib));
                end else begin
                    verifica("slot_len", 32'(pos), 32'(CG + CPD - 1));
                end
            end
        end
    end

    initial begin
        Digitos     = 16'h1234;
        Apagar_Zero = 1'b0;
`ifdef DISPLAY_PISCA_EN
        Seleciona_Pisca = 4'b1100;
`else
        Seleciona_Pisca = 4'b1111;
`endif
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        verifica("rst_enable", 32'(Habilita_Digito), 32'd0);
        verifica("rst_digito", 32'(Digito_Atual), 32'd0);
        verifica("rst_nibble", 32'(Num_Binario), 32'd0);
        @(posedge Clock);
        #1;
        Reset      = 1'b0;
        quadro_num = 1;
        fila.delete();
        empilha_quadro(16'h1234, 1'b0, 1);
        mon_en = 1'b1;

        quadro(16'h1234, 1'b0, 3);
        quadro(16'h0050, 1'b1, 3);
        quadro(16'h0000, 1'b1, 3);
        quadro(16'h1234, 1'b1, 3);
        quadro(16'h5678, 1'b1, 7);

        // Frame showing 5678: reset while digit 2 is lit
        repeat (12) @(posedge Clock);
        #1;
        Reset = 1'b1;
        fila.delete();
        quadro_num = 1;
        empilha_quadro(16'h5678, 1'b1, 1);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        verifica("midrst_digito", 32'(Digito_Atual), 32'd0);
        verifica("midrst_enable", 32'(Habilita_Digito), 32'd0);

        quadro(16'h0A0F, 1'b1, 3);
        quadro(16'h0A0F, 1'b1, 3);
        repeat (FRAME) @(posedge Clock);
        #1;
        mon_en = 1'b0;
        verifica("queue_drained", 32'(fila.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_display.md
# controle_display

Time-multiplexed scan controller for the alarm clock's multi-digit seven-segment display. Shares the single BCD-to-seven-segment decoder between all digit positions: it selects one digit's nibble onto the decoder input, drives the matching one-hot digit enable, and inserts a dead-time gap between digits to prevent ghosting. It also suppresses leading zeros and, optionally, blinks selected digits while the user sets the time or alarm. It sits between the timekeeping/alarm registers and the decoder plus the display digit drivers.

## Interface
Parameters:
- NUM_DIGITOS, 4: number of digit positions; index 0 is least significant.
- CICLOS_POR_DIGITO, 50000: clock cycles each digit is lit per visit; must be ≥1.
- CICLOS_GUARDA, 16: dead-time cycles with all digits off between visits; must be ≥1.
- CICLOS_PISCA, 12500000: half-period of the blink phase, in clock cycles; used only with DISPLAY_PISCA_EN.

Ports:
- Clock  in  1  single system clock; all state is updated on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Digitos  in  4*NUM_DIGITOS  packed BCD/hex nibbles; digit i is bits [4i+3:4i].
- Apagar_Zero  in  1  when 1, leading-zero suppression is enabled.
- Seleciona_Pisca  in  NUM_DIGITOS  per-digit blink request; ignored without DISPLAY_PISCA_EN.
- Num_Binario  out  4  nibble presented to the decoder.
- Habilita_Digito  out  NUM_DIGITOS  one-hot, active-high digit enable; all zero while blanked.
- Digito_Atual  out  clog2(NUM_DIGITOS)  index of the digit currently being scanned.

## Operation
- Two-state FSM:
  - GUARDA: all enables are 0. The FSM holds here for CICLOS_GUARDA cycles, then moves to ATIVO.
  - ATIVO: lit for CICLOS_POR_DIGITO cycles. Then Digito_Atual increments, wrapping from NUM_DIGITOS-1 to 0, and the FSM returns to GUARDA.
- Frame snapshot:
  - Digitos is latched into an internal register on every entry into GUARDA with Digito_Atual=0, including the first cycle after reset.
  - The displayed values are therefore coherent across a full scan frame; mid-frame changes to Digitos are not shown until the next frame.
- Num_Binario = snapshot nibble of Digito_Atual. It is registered and updates on the same cycle Digito_Atual changes, i.e. during GUARDA, so it is stable before the enable rises.
- Habilita_Digito in ATIVO = one-hot(Digito_Atual), unless that digit is suppressed.
- Leading-zero suppression, for digit i > 0: suppressed when Apagar_Zero=1 and all snapshot nibbles from NUM_DIGITOS-1 down to i equal 0. Digit 0 is never suppressed, so 0000 shows "0".
- Nibble values A–F are passed through unchanged; the decoder renders them.
- A suppressed digit still consumes its full time slot, so scan timing is independent of the displayed data.

## Timing
- Reset values: state=GUARDA, Digito_Atual=0, Num_Binario=0, Habilita_Digito=0, cycle counter=0, blink phase=0.
- Reset asserted mid-scan: outputs return to reset values on the next edge; the scan restarts at digit 0 with a fresh snapshot.
- Per-digit period = CICLOS_GUARDA + CICLOS_POR_DIGITO. Frame period = NUM_DIGITOS times that.
- Habilita_Digito rises exactly CICLOS_GUARDA cycles after Digito_Atual changes and falls on the cycle Digito_Atual next changes, with no overlap between digits.
- Counter width is clog2(max(CICLOS_POR_DIGITO, CICLOS_GUARDA)). The counter resets to 0 on every state change.

## Configuration
- DISPLAY_PISCA_EN defined:
  - A free-running counter toggles the blink phase every CICLOS_PISCA cycles.
  - While phase=1, any digit i with Seleciona_Pisca[i]=1 has its enable forced to 0 during ATIVO. Scan timing is unchanged.
  - Phase and counter are cleared by Reset.
- DISPLAY_PISCA_EN undefined:
  - No blink counter is built.
  - Seleciona_Pisca is unused; the port remains for a stable interface.

## Structure
- Package display_pkg holds:
  - the FSM state enum {GUARDA, ATIVO};
  - the BCD nibble width constant (4);
  - a helper function for one-hot digit encoding.
- Natural sub-module: gerador_pisca, the blink phase divisor. It is instantiated only under DISPLAY_PISCA_EN.
- The seven-segment decoder is instantiated by the parent, not inside this block.

## Test plan
Bench parameters: NUM_DIGITOS=4, CICLOS_POR_DIGITO=4, CICLOS_GUARDA=1, CICLOS_PISCA=20.
- Release reset with Digitos=16'h1234 → Habilita_Digito=0001 with Num_Binario=4 on cycles 2–5, then 0010 with 3, 0100 with 2, 1000 with 1. The pattern repeats every 20 cycles, and enables never overlap.
- Apagar_Zero=1, Digitos=16'h0050 → digits 3 and 2 are never enabled; digits 1 (5) and 0 (0) are lit. Digitos=16'h0000 → only digit 0 is lit, showing 0.
- Change Digitos from 16'h1234 to 16'h5678 while digit 1 is lit → digits 2 and 3 still show 2 and 1. The next frame shows 8, 7, 6, 5.
- Assert Reset for 1 cycle during ATIVO of digit 2 → next cycle: Habilita_Digito=0, Digito_Atual=0, state GUARDA. Digit 0 is lit 1 cycle later.
- With DISPLAY_PISCA_EN, Seleciona_Pisca=4'b1100 → digits 3 and 2 are dark for 20 cycles, lit for 20 cycles, alternating. Digits 1 and 0 are lit every frame.
- Without DISPLAY_PISCA_EN, Seleciona_Pisca=4'b1111 → output identical to Seleciona_Pisca=0.
